// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a single-entry
// valid/ready output buffer that reports framing errors and overruns as one-cycle pulses.
module uart_rx_8n1 #(
  parameter  int CLKS_PER_BIT = 868,
  localparam int CTR_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int H = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CTR_W-1:0] r_ctr;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_rx_meta;
  logic             r_rx_sync;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_overrun;

  logic             w_half;
  logic             w_full;
  logic             w_ctr_clr;
  logic             w_sample_data;
  logic             w_byte_done;
  logic             w_frame_err;
  logic             w_load_ok;

  assign w_half    = (r_ctr == CTR_W'(H - 1));
  assign w_full    = (r_ctr == CTR_W'(CLKS_PER_BIT - 1));
  assign w_load_ok = !r_valid || ready;

  // Idle-high line, so the synchroniser resets to 1 to avoid a false start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // pre-edge values; blocking here would collapse the two synchroniser stages.
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that leaves one
    // unassigned would infer a latch.
    w_state_next  = r_state;
    w_ctr_clr     = 1'b0;
    w_sample_data = 1'b0;
    w_byte_done   = 1'b0;
    w_frame_err   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ctr_clr = 1'b1;
        if (!r_rx_sync) w_state_next = S_START;
      end
      S_START: begin
        if (w_half) begin
          w_ctr_clr    = 1'b1;
          w_state_next = r_rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_full) begin
          w_ctr_clr     = 1'b1;
          w_sample_data = 1'b1;
          if (r_bit_idx == 3'd7) w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_full) begin
          w_ctr_clr = 1'b1;
          if (r_rx_sync) begin
            w_byte_done  = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A held-low line must not look like a stream of start bits.
        w_ctr_clr = 1'b1;
        if (r_rx_sync) w_state_next = S_IDLE;
      end
      default: begin
        w_ctr_clr    = 1'b1;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctr     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_ctr <= w_ctr_clr ? '0 : r_ctr + CTR_W'(1);
      if (r_state == S_START) begin
        r_bit_idx <= '0;
      end else if (w_sample_data) begin
        r_bit_idx <= r_bit_idx + 3'd1;
        r_shift   <= {r_rx_sync, r_shift[7:1]};
      end
    end
  end

  // Output buffer: a completing byte may replace data only when the slot is empty
  // or is being drained in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= w_byte_done && !w_load_ok;
      if (w_byte_done && w_load_ok) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1 at 16 clocks per bit: expected bytes go into a
// scoreboard queue as frames are sent and are popped when valid rises.
module tb_uart_rx_8n1;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  int         tests;
  int         fails;
  int         valid_cnt;
  int         ferr_cnt;
  int         ovr_cnt;
  logic       prev_valid;
  logic       expect_drop;
  logic [7:0] sb_q[$];

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: all outputs sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [7:0] exp_byte;
    if (expect_drop) begin
      check("valid_drop", {31'd0, valid}, 32'd0);
      expect_drop = 1'b0;
    end
    if (valid && !prev_valid) begin
      valid_cnt++;
      exp_byte = 8'hxx;
      if (sb_q.size() != 0) exp_byte = sb_q.pop_front();
      check("rx_data", {24'd0, data}, {24'd0, exp_byte});
      if (ready) expect_drop = 1'b1;
    end
    if (frame_err) ferr_cnt++;
    if (overrun)   ovr_cnt++;
    if (frame_err || overrun)
      check("flags_exclusive", {31'd0, frame_err && overrun}, 32'd0);
    prev_valid = valid;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait until every expected byte has been seen.
  task automatic wait_drain(input string tag);
    int budget;
    budget = 400;
    while (sb_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, sb_q.size(), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    valid_cnt   = 0;
    ferr_cnt    = 0;
    ovr_cnt     = 0;
    prev_valid  = 1'b0;
    expect_drop = 1'b0;
    rx          = 1'b1;
    ready       = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data",      {24'd0, data},      32'd0);
    check("reset_valid",     {31'd0, valid},     32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_overrun",   {31'd0, overrun},   32'd0);
    rst_n = 1'b1;
    idle(10);

    // 1: single byte with ready held high
    ready = 1'b1;
    sb_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    idle(8);
    wait_drain("t1_drain");
    check("t1_valid_cnt", valid_cnt, 32'd1);
    check("t1_ferr",      ferr_cnt,  32'd0);
    check("t1_ovr",       ovr_cnt,   32'd0);

    // 2: 4-cycle glitch must abort in START
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(60);
    check("t2_valid_cnt", valid_cnt,      32'd1);
    check("t2_ferr",      ferr_cnt,       32'd0);
    check("t2_ovr",       ovr_cnt,        32'd0);
    check("t2_valid",     {31'd0, valid}, 32'd0);

    // 3: framing error followed by a long break, then a good byte
    send_byte(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (100) @(negedge clk);
    idle(20);
    check("t3_ferr_once",  ferr_cnt,  32'd1);
    check("t3_no_valid",   valid_cnt, 32'd1);
    sb_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    idle(8);
    wait_drain("t3_drain");
    check("t3_valid_cnt",  valid_cnt, 32'd2);
    check("t3_ferr_final", ferr_cnt,  32'd1);

    // 4: overrun while the buffer is held full
    ready = 1'b0;
    sb_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(8);
    wait_drain("t4_drain");
    check("t4_ovr",      ovr_cnt,        32'd1);
    check("t4_data",     {24'd0, data},  32'h11);
    check("t4_valid",    {31'd0, valid}, 32'd1);
    check("t4_ferr",     ferr_cnt,       32'd1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("t4_consumed", {31'd0, valid}, 32'd0);
    idle(4);

    // 5: reset during bit 4 of 0xFF, then a fresh frame
    ready = 1'b1;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, valid}, 32'd0);
    check("t5_rst_data",  {24'd0, data},  32'd0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(40);
    check("t5_no_partial", valid_cnt, 32'd3);
    sb_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    idle(8);
    wait_drain("t5_drain");
    check("t5_valid_cnt", valid_cnt, 32'd4);

    // 6: back-to-back frames with no idle gap
    sb_q.push_back(8'h00);
    sb_q.push_back(8'hFF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(8);
    wait_drain("t6_drain");
    check("t6_valid_cnt", valid_cnt, 32'd6);
    check("t6_ferr",      ferr_cnt,  32'd1);
    check("t6_ovr",       ovr_cnt,   32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- Serial receiver for the USB-to-serial input line, 8 data bits, no parity, 1 stop bit (8N1).
- Sits directly downstream of the board top level's usb_rx pin. Converts the asynchronous serial stream into bytes delivered over a valid/ready handshake to the consumer logic (LED display, command parser).
- Single-entry output buffer; flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200 baud); must be >= 8.
- CTR_W, $clog2(CLKS_PER_BIT), width of the bit-timing counter (derived, not overridden).

Ports:
- clk  input  1  100 MHz system clock.
- rst_n  input  1  reset; asynchronous and active-low.
- rx  input  1  raw serial line; idle high, asynchronous to clk.
- data  output  8  received byte; stable while valid=1.
- valid  output  1  data holds an unconsumed byte.
- ready  input  1  consumer accepts data this cycle when valid=1.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good byte dropped because the buffer was full.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: data=0, valid=0, frame_err=0, overrun=0.
  - Internal: state=IDLE, counter=0, bit index=0, both synchroniser flops=1.
- Synchroniser: rx passes through 2 flops; rxs is the second flop. All decisions use rxs only.
- Timing constant H = CLKS_PER_BIT/2 (integer floor).
- The counter resets to 0 on every state entry and on every bit sample.
- IDLE:
  - rxs==0 -> START.
- START:
  - When counter==H-1, sample rxs.
  - rxs==0 -> DATA, bit index=0.
  - rxs==1 (glitch) -> IDLE, no flags raised.
- DATA:
  - When counter==CLKS_PER_BIT-1, sample rxs into the shift register, LSB first.
  - After bit index 7 is sampled -> STOP; otherwise increment bit index.
- STOP:
  - When counter==CLKS_PER_BIT-1, sample rxs.
  - rxs==1 -> byte complete; go to IDLE and perform buffer load.
  - rxs==0 -> frame_err=1 for exactly one cycle, byte discarded -> BREAK.
- BREAK:
  - Remain until rxs==1, then -> IDLE.
  - A held-low line (break condition) yields exactly one frame_err, not repeated starts.
- Buffer load (on the completion cycle):
  - If valid==0, or valid==1 and ready==1 in the same cycle: data<=byte and valid<=1 on the next edge.
  - Else: overrun=1 for one cycle; new byte dropped; data and valid unchanged.
- Consumer transfer:
  - valid&&ready with no simultaneous load -> valid<=0 next edge.
  - ready is ignored while valid==0.
  - data is never modified while valid==1 except on a simultaneous transfer plus load.
- Latency: valid rises on the clock edge after the stop-bit sample. The stop-bit sample falls approximately 2 + H + 9*CLKS_PER_BIT cycles after rx falls (±1 cycle synchroniser uncertainty).
- Back-to-back frames: the IDLE detection one cycle after STOP must accept a start edge immediately; no inter-frame gap is required.
- Reset mid-frame: everything returns to reset values at once; the partial byte is lost. After release, a frame whose start edge occurs while in IDLE is received normally.
- frame_err and overrun are never asserted in the same cycle; they have distinct causes.

Test Plan:
- All scenarios use CLKS_PER_BIT=16.
1. Idle line, ready=1, send 0xA5 -> valid=1 with data=0xA5, valid drops the next cycle; frame_err=0, overrun=0.
2. Drive rx low for 4 cycles, then high -> START aborts to IDLE; valid, frame_err and overrun all stay 0.
3. Send 0x3C with stop bit=0, hold rx low for 100 cycles, then high, then send 0x55 -> exactly one frame_err pulse, no valid for 0x3C; 0x55 delivered correctly.
4. ready=0, send 0x11 then 0x22 -> valid=1 with data=0x11; one overrun pulse at the second stop; data stays 0x11. Raise ready for 1 cycle -> valid=0 on the next edge.
5. Assert rst_n=0 during bit 4 of 0xFF -> valid=0 and state=IDLE immediately. Release, send 0x81 -> data=0x81, valid=1.
6. ready=1, send 0x00 and 0xFF with no idle gap between frames -> two valid pulses, with data 0x00 then 0xFF; no flags.
